// File: rtl/asip_mem_pkg.sv
// Shared constants for the ASIP data-memory responder: MMIO map, STATUS layout
// and word width, plus the STATUS word packer.
package asip_mem_pkg;

  localparam int WORD_W = 24;

  localparam logic [15:0] MMIO_BASE = 16'hFF00;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_LEDS   = 4'h1;
  localparam logic [3:0] OFF_TXDATA = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_COUNT_MSB = 3;
  localparam int ST_FULL      = 4;
  localparam int ST_EMPTY     = 5;
  localparam int ST_OVERFLOW  = 8;

  function automatic logic [WORD_W-1:0] pack_status(
    input logic [3:0] count,
    input logic       full,
    input logic       empty,
    input logic       overflow
  );
    logic [WORD_W-1:0] s;
    s = '0;
    s[ST_COUNT_MSB:ST_COUNT_LSB] = count;
    s[ST_FULL]     = full;
    s[ST_EMPTY]    = empty;
    s[ST_OVERFLOW] = overflow;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_responder_stream_fifo.sv
// Circular-buffer output FIFO; head word is shown combinationally.
// Handshake: a push is taken only when not full; a pop happens at an edge with
// pop (ready) high while non-empty; head stays stable until that pop.
module stream_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Full is judged on the start-of-cycle count, so a same-cycle pop never makes room.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational-read RAM plus an MMIO window holding a
// cycle counter, an LED register and a buffered output stream.
module data_mem_responder
  import asip_mem_pkg::*;
#(
  parameter int    DEPTH      = 1024,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       A,
  input  logic [WORD_W-1:0] memWD,
  input  logic              memWriteM,
  output logic [WORD_W-1:0] rdMemData,
  output logic [WORD_W-1:0] leds,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] ram [DEPTH];
  logic [WORD_W-1:0] cycle_count;
  logic              overflow;
  logic              is_mmio;
  logic [3:0]        off;
  logic [AW-1:0]     ram_addr;
  logic              mmio_we;
  logic              tx_push;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] status;

  assign is_mmio  = (A >= MMIO_BASE);
  assign off      = A[3:0];
  // RAM addresses alias modulo DEPTH by keeping only the low bits.
  assign ram_addr = A[AW-1:0];
  assign mmio_we  = memWriteM && is_mmio && !rst;
  assign tx_push  = mmio_we && (off == OFF_TXDATA);
  assign status   = pack_status(4'(fifo_count), fifo_full, fifo_empty, overflow);

  stream_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .push_data(memWD),
    .pop      (out_ready),
    .head     (out_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst && memWriteM && !is_mmio) ram[ram_addr] <= memWD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      leds        <= '0;
      overflow    <= 1'b0;
    end else begin
      cycle_count <= (mmio_we && off == OFF_CYCLE) ? '0 : cycle_count + 1'b1;
      if (mmio_we && off == OFF_LEDS) leds <= memWD;
      if (mmio_we && off == OFF_STATUS) overflow <= 1'b0;
      else if (tx_push && fifo_full)    overflow <= 1'b1;
    end
  end

  always_comb begin
    rdMemData = '0;
    if (!is_mmio) begin
      rdMemData = ram[ram_addr];
    end else begin
      case (off)
        OFF_CYCLE:  rdMemData = cycle_count;
        OFF_LEDS:   rdMemData = leds;
        OFF_STATUS: rdMemData = status;
        default:    rdMemData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a queue/array model tracks RAM, MMIO
// and the stream, checked every cycle, plus hand-computed literal expectations.
module tb_data_mem_responder;
  import asip_mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int FD    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [23:0] memWD;
  logic        memWriteM;
  logic [23:0] rdMemData;
  logic [23:0] leds;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;
  int preset_seq = 0;
  int seen_seq   = 0;

  data_mem_responder #(
    .DEPTH(DEPTH),
    .FIFO_DEPTH(FD),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .memWD(memWD),
    .memWriteM(memWriteM),
    .rdMemData(rdMemData),
    .leds(leds),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // clock
  always #5 clk = ~clk;

  // behavioural model state
  logic [23:0] m_cycle;
  logic [23:0] m_leds;
  bit          m_ovf;
  logic [23:0] exp_q[$];
  logic [23:0] m_ram[int];

  always @(posedge clk) begin
    bit do_pop;
    bit was_full;
    bit do_push;
    if (preset_seq != seen_seq) begin
      m_cycle  = 24'hFFFFFE;
      seen_seq = preset_seq;
    end
    if (rst) begin
      m_cycle = 24'd0;
      m_leds  = 24'd0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      do_pop   = (exp_q.size() != 0) && out_ready;
      was_full = (exp_q.size() == FD);
      do_push  = 1'b0;
      m_cycle  = m_cycle + 24'd1;
      if (memWriteM) begin
        if (A >= 16'hFF00) begin
          case (A[3:0])
            4'h0: m_cycle = 24'd0;
            4'h1: m_leds = memWD;
            4'h2: do_push = 1'b1;
            4'h3: m_ovf = 1'b0;
            default: ;
          endcase
        end else begin
          m_ram[int'(A) % DEPTH] = memWD;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (was_full) m_ovf = 1'b1;
        else exp_q.push_back(memWD);
      end
    end
  end

  function automatic void exp_read(input logic [15:0] a, output logic [23:0] v, output bit known);
    known = 1'b1;
    v = 24'd0;
    if (a >= 16'hFF00) begin
      case (a[3:0])
        4'h0: v = m_cycle;
        4'h1: v = m_leds;
        4'h3: v = (24'(m_ovf) << 8) | (24'(exp_q.size() == 0) << 5) |
                  (24'(exp_q.size() == FD) << 4) | 24'(exp_q.size());
        default: v = 24'd0;
      endcase
    end else if (m_ram.exists(int'(a) % DEPTH)) begin
      v = m_ram[int'(a) % DEPTH];
    end else begin
      known = 1'b0;
    end
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] ev;
    bit kn;
    if (check_en) begin
      exp_read(A, ev, kn);
      if (kn) chk("model_rd", rdMemData, ev);
      chk("model_leds", leds, m_leds);
      chk("model_valid", 24'(out_valid), 24'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("model_head", out_data, exp_q[0]);
    end
  end

  // driver: apply one cycle of inputs, return at that cycle's falling edge
  task automatic step(input logic [15:0] a, input logic [23:0] wd, input bit we, input bit rdy);
    @(posedge clk);
    #1;
    A         = a;
    memWD     = wd;
    memWriteM = we;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; A = 16'hFF00; memWD = '0; memWriteM = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // CYCLE counts from reset release
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("cycle_after_10", rdMemData, 24'd10);
    step(16'hFF00, 24'h000123, 1'b1, 1'b0);
    step(16'hFF00, 24'h0, 1'b0, 1'b0);
    chk("cycle_cleared", rdMemData, 24'd0);
    step(16'hFF00, 24'h0, 1'b0, 1'b0);
    chk("cycle_after_clear", rdMemData, 24'd1);
    #2;
    force dut.cycle_count = 24'hFFFFFE;
    preset_seq++;
    #1;
    release dut.cycle_count;
    step(16'hFF00, 24'h0, 1'b0, 1'b0);
    chk("cycle_max", rdMemData, 24'hFFFFFF);
    step(16'hFF00, 24'h0, 1'b0, 1'b0);
    chk("cycle_wrap", rdMemData, 24'd0);

    // RAM write/read and aliasing
    step(16'd5, 24'h111111, 1'b1, 1'b0);
    step(16'd5, 24'hABCDEF, 1'b1, 1'b0);
    chk("ram_old_in_write_cycle", rdMemData, 24'h111111);
    step(16'd5, 24'h0, 1'b0, 1'b0);
    chk("ram_new", rdMemData, 24'hABCDEF);
    step(16'(DEPTH + 5), 24'h0, 1'b0, 1'b0);
    chk("ram_alias", rdMemData, 24'hABCDEF);

    // FIFO fill past capacity
    for (int i = 1; i <= 9; i++) step(16'hFF02, 24'(i), 1'b1, 1'b0);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_full_ovf", rdMemData, 24'h000118);
    step(16'd5, 24'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      chk("drain_order", out_data, 24'(i));
    end
    @(negedge clk);
    chk("drained_valid", 24'(out_valid), 24'd0);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_empty_ovf", rdMemData, 24'h000120);
    step(16'hFF03, 24'h0, 1'b1, 1'b0);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_ovf_cleared", rdMemData, 24'h000020);

    // simultaneous push and pop
    for (int i = 10; i <= 12; i++) step(16'hFF02, 24'(i), 1'b1, 1'b0);
    step(16'hFF02, 24'd13, 1'b1, 1'b1);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_push_pop", rdMemData, 24'h000003);
    chk("head_push_pop", out_data, 24'd11);
    for (int i = 14; i <= 18; i++) step(16'hFF02, 24'(i), 1'b1, 1'b0);
    step(16'hFF02, 24'd99, 1'b1, 1'b1);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_full_push_pop", rdMemData, 24'h000107);
    chk("head_full_push_pop", out_data, 24'd12);
    step(16'hFF03, 24'h0, 1'b1, 1'b0);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_clear", rdMemData, 24'h000007);

    // LEDS and unmapped offsets
    step(16'hFF01, 24'h00F0F0, 1'b1, 1'b0);
    step(16'hFF01, 24'h0, 1'b0, 1'b0);
    chk("leds_readback", rdMemData, 24'h00F0F0);
    chk("leds_port", leds, 24'h00F0F0);
    step(16'hFF07, 24'h0, 1'b0, 1'b0);
    chk("unmapped_read", rdMemData, 24'd0);
    step(16'hFF07, 24'h123456, 1'b1, 1'b0);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("unmapped_write_status", rdMemData, 24'h000007);
    chk("unmapped_write_leds", leds, 24'h00F0F0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) step(16'd5, 24'h0, 1'b0, 1'b1);
    step(16'hFF01, 24'd5, 1'b1, 1'b0);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("status_before_rst", rdMemData, 24'h000004);
    chk("leds_before_rst", leds, 24'd5);
    @(posedge clk);
    #1;
    rst = 1'b1; A = 16'd5; memWD = 24'h777777; memWriteM = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; A = 16'hFF00; memWriteM = 1'b0;
    @(negedge clk);
    chk("rst_valid", 24'(out_valid), 24'd0);
    chk("rst_leds", leds, 24'd0);
    chk("rst_cycle", rdMemData, 24'd0);
    step(16'd5, 24'h0, 1'b0, 1'b0);
    chk("rst_ram_kept", rdMemData, 24'hABCDEF);
    step(16'hFF03, 24'h0, 1'b0, 1'b0);
    chk("rst_status", rdMemData, 24'h000020);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
